// File: rtl/stream_arbiter.sv
// stream_arbiter: NUM-way packet-aware round-robin arbiter feeding one
// valid/ready stream (shared fifo write side). Grant, data mux and in_ready
// are combinational; only state, owner and rr_ptr are registered.
// Optional feature: define STREAM_ARBITER_LOCK_EN to hold the grant for a
// whole packet (until in_last). Without it every transferred beat
// re-arbitrates, and only a stalled beat holds the grant.

// Per-requester slice: decodes "am I granted", produces in_ready and this
// requester's contribution to the AND-OR output data mux.
module stream_arbiter_lane #(
  parameter int WIDTH = 8,
  parameter int IDW   = 2,
  parameter int IDX   = 0
) (
  input  logic [IDW-1:0]   grant,
  input  logic             active,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_sel
);
  logic sel;

  assign sel      = (grant == IDW'(IDX));
  assign ready    = active & sel & out_ready;
  assign data_sel = sel ? data : '0;
endmodule

module stream_arbiter #(
  parameter int NUM   = 4,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM-1:0]            in_valid,
  output logic [NUM-1:0]            in_ready,
  input  logic [NUM*WIDTH-1:0]      in_data,
  input  logic [NUM-1:0]            in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [$clog2(NUM)-1:0]    out_id
);
  localparam int IDW = $clog2(NUM);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state;
  logic [IDW-1:0]             rr_ptr;
  logic [IDW-1:0]             owner;
  logic [IDW-1:0]             scan_grant;
  logic                       scan_hit;
  logic [IDW:0]               idx_sum;
  logic [IDW-1:0]             grant;
  logic                       active;
  logic                       xfer;
  logic                       eff_last;
  logic [NUM-1:0][WIDTH-1:0]  lane_data;
  logic [NUM:0][WIDTH-1:0]    data_or;

  // Wrapping increment that also works when NUM is not a power of two.
  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NUM-1)) ? '0 : p + 1'b1;
  endfunction

  // Cyclic priority scan starting at rr_ptr; scanning from the far end
  // backwards lets the requester closest to rr_ptr win the last write.
  always_comb begin
    scan_grant = rr_ptr;
    scan_hit   = 1'b0;
    idx_sum    = '0;
    for (int k = NUM-1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx_sum >= (IDW+1)'(NUM)) idx_sum = idx_sum - (IDW+1)'(NUM);
      if (in_valid[idx_sum[IDW-1:0]]) begin
        scan_grant = idx_sum[IDW-1:0];
        scan_hit   = 1'b1;
      end
    end
  end

  // A locked owner keeps the grant through bubbles; an idle arbiter with no
  // requests parks on rr_ptr and drives no in_ready.
  assign grant     = (state == LOCKED) ? owner : scan_grant;
  assign active    = !rst && ((state == LOCKED) || scan_hit);
  assign out_valid = !rst && in_valid[grant];
  assign out_last  = in_last[grant];
  assign out_id    = grant;
  assign xfer      = out_valid & out_ready;

`ifdef STREAM_ARBITER_LOCK_EN
  assign eff_last = out_last;
`else
  assign eff_last = 1'b1;
`endif

  assign data_or[0] = '0;

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    stream_arbiter_lane #(
      .WIDTH (WIDTH),
      .IDW   (IDW),
      .IDX   (i)
    ) u_lane (
      .grant     (grant),
      .active    (active),
      .out_ready (out_ready),
      .data      (in_data[i*WIDTH +: WIDTH]),
      .ready     (in_ready[i]),
      .data_sel  (lane_data[i])
    );
    assign data_or[i+1] = data_or[i] | lane_data[i];
  end

  assign out_data = data_or[NUM];

  // Lock/unlock FSM: a finished packet advances rr_ptr past its sender; any
  // offered beat that is not a finished packet pins the grant to its sender.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid) begin
            if (xfer && eff_last) begin
              rr_ptr <= ptr_inc(grant);
            end else begin
              state <= LOCKED;
              owner <= grant;
            end
          end
        end
        LOCKED: begin
          if (xfer && eff_last) begin
            state  <= IDLE;
            rr_ptr <= ptr_inc(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter (NUM=4, WIDTH=8). Expected beats are
// queued as stimulus is driven and matched when the DUT transfers a beat.
module tb_stream_arbiter;
  localparam int NUM   = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM-1:0]        in_valid;
  logic [NUM-1:0]        in_ready;
  logic [NUM*WIDTH-1:0]  in_data;
  logic [NUM-1:0]        in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [IDW-1:0]        out_id;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t sb[$];
  int    n_pass  = 0;
  int    n_total = 0;

  stream_arbiter #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push(input int id, input int data, input bit last);
    beat_t b;
    b.id   = id[IDW-1:0];
    b.data = data[WIDTH-1:0];
    b.last = last;
    sb.push_back(b);
  endtask

  task automatic set_req(input int i, input bit v, input int d, input bit l);
    in_valid[i]              = v;
    in_data[i*WIDTH +: WIDTH] = d[WIDTH-1:0];
    in_last[i]               = l;
  endtask

  // Match a transferring beat against the head of the scoreboard.
  task automatic mon();
    beat_t e;
    if (out_valid && out_ready) begin
      n_total++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL sb_unexpected observed=id%0d data=0x%0h expected=no beat", out_id, out_data);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_id",   32'(out_id),   32'(e.id));
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_last", 32'(out_last), 32'(e.last));
      end
    end
  endtask

  // Inputs are driven 1ns after the edge; outputs are sampled 2ns after.
  task automatic tick();
    #1;
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, b1;
    logic [NUM-1:0] rdy;

    // Reset with every requester asking: nothing may be accepted.
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = '1;
    in_last   = '1;
    for (int i = 0; i < NUM; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(8'hA0 + i);
    @(posedge clk);
    #1;
    repeat (2) begin
      #1;
      chk("rst_ready", 32'(in_ready), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      tick();
    end
    rst = 1'b0;

    // Round robin of single-beat packets, one beat per cycle.
    for (int c = 0; c < 5; c++) begin
      push(c % 4, 'hA0 + c % 4, 1'b1);
      #1;
      chk("rr_ready", 32'(in_ready), 32'(1) << (c % 4));
      tick();
    end

    // No requests: parked on rr_ptr (=1), nothing offered.
    in_valid = '0;
    #1;
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_id",    32'(out_id),    32'h1);
    chk("idle_ready", 32'(in_ready),  32'h0);
    tick();

    // Stall: requester 1 granted, requester 0 shows up mid-stall.
    set_req(1, 1'b1, 'h55, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) set_req(0, 1'b1, 'h11, 1'b1);
      #1;
      chk("stall_id",    32'(out_id),   32'h1);
      chk("stall_data",  32'(out_data), 32'h55);
      chk("stall_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    push(1, 'h55, 1'b1);
    tick();
    set_req(1, 1'b0, 0, 1'b0);
    push(0, 'h11, 1'b1);
    tick();
    set_req(0, 1'b0, 0, 1'b0);

`ifdef STREAM_ARBITER_LOCK_EN
    // Move rr_ptr to 2, then a 3-beat packet from 2 with a bubble while 1 waits.
    set_req(1, 1'b1, 'h66, 1'b1);
    push(1, 'h66, 1'b1);
    tick();
    set_req(1, 1'b1, 'h77, 1'b1);
    set_req(2, 1'b1, 'hC0, 1'b0);
    push(2, 'hC0, 1'b0);
    #1;
    chk("lock_ready0", 32'(in_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 'hC0, 1'b0);
    #1;
    chk("lock_bub_id",    32'(out_id),      32'h2);
    chk("lock_bub_valid", 32'(out_valid),   32'h0);
    chk("lock_bub_r1",    32'(in_ready[1]), 32'h0);
    tick();
    set_req(2, 1'b1, 'hC1, 1'b0);
    push(2, 'hC1, 1'b0);
    #1;
    chk("lock_b1_id", 32'(out_id),      32'h2);
    chk("lock_b1_r1", 32'(in_ready[1]), 32'h0);
    tick();
    set_req(2, 1'b1, 'hC2, 1'b1);
    push(2, 'hC2, 1'b1);
    #1;
    chk("lock_b2_id", 32'(out_id),      32'h2);
    chk("lock_b2_r1", 32'(in_ready[1]), 32'h0);
    tick();
    set_req(2, 1'b0, 0, 1'b0);
    push(1, 'h77, 1'b1);
    #1;
    chk("lock_next", 32'(out_id), 32'h1);
    tick();
    set_req(1, 1'b0, 0, 1'b0);
`endif

    // Reset during beat 2 of a 4-beat packet from requester 3.
    set_req(3, 1'b1, 'h30, 1'b0);
    push(3, 'h30, 1'b0);
    tick();
    set_req(3, 1'b1, 'h31, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 32'(out_valid), 32'h0);
    chk("rstmid_ready", 32'(in_ready),  32'h0);
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 'h0F, 1'b1);
    push(0, 'h0F, 1'b1);
    #1;
    chk("rstmid_id", 32'(out_id), 32'h0);
    tick();
    set_req(0, 1'b0, 0, 1'b0);
    set_req(3, 1'b0, 0, 1'b0);

    // Two 2-beat packets from requesters 0 and 1, starting from rr_ptr=0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef STREAM_ARBITER_LOCK_EN
    push(0, 'hD0, 1'b0); push(0, 'hD1, 1'b1);
    push(1, 'hE0, 1'b0); push(1, 'hE1, 1'b1);
`else
    push(0, 'hD0, 1'b0); push(1, 'hE0, 1'b0);
    push(0, 'hD1, 1'b1); push(1, 'hE1, 1'b1);
`endif
    b0 = 0;
    b1 = 0;
    for (int c = 0; c < 4; c++) begin
      set_req(0, b0 < 2, 'hD0 + b0, b0 == 1);
      set_req(1, b1 < 2, 'hE0 + b1, b1 == 1);
      #1;
      rdy = in_ready;
      tick();
      if (rdy[0]) b0++;
      if (rdy[1]) b1++;
    end

    in_valid = '0;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter NUM, default 4: number of requesters, legal range 2..16.
REQ-002 Parameter WIDTH, default 8: data width per beat.
REQ-003 Localparam IDW = $clog2(NUM): width of the requester index.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, NUM: per-requester beat valid.
REQ-007 Port in_ready, output, NUM: per-requester beat accepted.
REQ-008 Port in_data, input, NUM*WIDTH: requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port in_last, input, NUM: per-requester final beat of packet.
REQ-010 Port out_valid, output, 1: beat valid towards the shared fifo write side.
REQ-011 Port out_ready, input, 1: shared fifo w_ready.
REQ-012 Port out_data, output, WIDTH: data of the granted requester.
REQ-013 Port out_last, output, 1: in_last of the granted requester.
REQ-014 Port out_id, output, IDW: index of the granted requester.

Function
REQ-015 A transfer is defined on any edge where valid and ready are both high on the same side.
REQ-016 State machine SHALL have two states, IDLE and LOCKED, plus registers owner[IDW] and rr_ptr[IDW].
- IDLE grant: first i with in_valid[i]=1, scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... wrapping NUM-1 -> 0).
- LOCKED grant: owner.
REQ-017 Datapath to output SHALL be combinational, zero-cycle.
- out_valid = in_valid[grant].
- out_data, out_last and out_id follow grant.
- in_ready[grant] = out_ready; every other in_ready bit = 0.
REQ-018 IDLE with no in_valid bit set: out_valid=0, in_ready=0, out_id=rr_ptr, no state change.
REQ-019 IDLE, out_valid=1, transfer with in_last=1: stay IDLE; rr_ptr <= grant+1 mod NUM.
REQ-020 IDLE, out_valid=1, and either no transfer or in_last=0: go to LOCKED; owner <= grant.
- If a transfer occurred, rr_ptr is unchanged.
- Consequence: a stalled beat never changes requester.
REQ-021 LOCKED, transfer with in_last=1: go to IDLE; rr_ptr <= owner+1 mod NUM.
REQ-022 LOCKED, any other cycle, including in_valid[owner]=0 bubbles: stay LOCKED.
- Other requesters are never granted, regardless of their in_valid.
REQ-023 A single-beat packet (in_last=1 on its first beat) SHALL complete in IDLE in one cycle.
- Back-to-back single beats from different requesters SHALL sustain one beat per cycle.
REQ-024 rr_ptr wrap: NUM-1 increments to 0, including when NUM is not a power of two.
REQ-025 Starvation bound: a requester holding in_valid=1 SHALL be granted before any other requester completes two packets.

Reset
REQ-026 On rst=1 at a rising edge: state <= IDLE, rr_ptr <= 0, owner <= 0.
REQ-027 While rst=1, out_valid and all in_ready bits SHALL be forced 0.
REQ-028 Reset mid-packet SHALL abandon the lock with no partial-packet completion.
- The next grant after release SHALL follow REQ-016 from rr_ptr=0.

Configuration
REQ-029 Macro STREAM_ARBITER_LOCK_EN.
- Defined: packet locking per REQ-020 to REQ-022.
- Undefined: in_last is treated as 1 for all state transitions.
  - Re-arbitration after every transferred beat.
  - LOCKED is entered only on a stalled beat (out_valid=1, out_ready=0) and released by that beat's transfer.
  - out_last still passes in_last through unchanged.

Verification (NUM=4, WIDTH=8, LOCK_EN defined unless stated)
REQ-030 Reset check: rst high 2 cycles with all in_valid=1 -> in_ready=4'b0000 and out_valid=0; first cycle after release grants 0.
REQ-031 Round robin: all requesters send single-beat packets 0xA0+i continuously, out_ready=1 -> out_id sequence 0,1,2,3,0.
- out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0, one beat per cycle.
REQ-032 Packet lock: requester 2 sends a 3-beat packet with a 1-cycle in_valid bubble while requester 1 is valid.
- out_id stays 2 for all 3 beats and the bubble.
- in_ready[1]=0 throughout; the next grant is 3 if requester 3 is valid, else 0, else 1.
REQ-033 Stall stability: out_ready=0 for 5 cycles with requester 1 granted, then requester 0 asserts -> out_id stays 1 and out_data stays stable until the transfer.
REQ-034 Reset mid-packet: rst pulsed during beat 2 of 4 from requester 3 -> after release, requester 0 is granted first if valid.
REQ-035 LOCK_EN undefined: requesters 0 and 1 each send 2-beat packets -> out_id sequence 0,1,0,1.
